serial_to_parallel_com_align: RTL and testbench



---
 rtl/serial_to_parallel_com_align.sv | 82 ++++++++
 tb/tb_serial_to_parallel_com_align.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_com_align.sv
// Serial-to-parallel RX deserialiser with COM-symbol byte alignment.
// Hunts bit-by-bit for COM, locks after BC_LOCK aligned COMs, then holds bytes.
module serial_to_parallel_com_align #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter int         BC_LOCK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

  state_t     state;
  logic [7:0] sh;
  logic [7:0] sh_n;
  logic [2:0] cnt;
  logic [3:0] bc_cnt;
  logic       bnd;
  logic       is_com;

  assign sh_n   = {sh[6:0], data_in};
  assign bnd    = (cnt == 3'd7);
  assign is_com = (sh_n == COM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      sh        <= 8'h00;
      cnt       <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sh <= sh_n;
      unique case (state)
        SEARCH: begin
          if (is_com) begin
            cnt    <= 3'd0;
            bc_cnt <= 4'd1;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          cnt <= cnt + 3'd1;
          if (bnd) begin
            if (is_com) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == LOCK_N) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              // Misaligned byte: drop lock progress, hunt from next bit.
              bc_cnt <= 4'd0;
              state  <= SEARCH;
            end
          end
        end
        LOCKED: begin
          cnt <= cnt + 3'd1;
          if (bnd) begin
            data_out  <= sh_n;
            valid_out <= !is_com;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_com_align.sv
// Scoreboard bench for serial_to_parallel_com_align.
// Per-cycle expected outputs are queued at each edge and checked on negedge.
module tb_serial_to_parallel_com_align;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  serial_to_parallel_com_align #(
    .COM    (8'hBC),
    .BC_LOCK(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  int          n_cmp;
  int          n_bad;
  string       phase;
  logic [9:0]  sb[$];
  logic [7:0]  cur_d;
  logic        cur_v;
  logic        cur_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h want %h @%0t", phase, tag, got, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("data_out", data_out, e[9:2]);
      chk("valid_out", {7'd0, valid_out}, {7'd0, e[1]});
      chk("active", {7'd0, active}, {7'd0, e[0]});
    end
  end

  task automatic drive_bit(input logic b, input logic [7:0] ed,
                           input logic ev, input logic ea);
    data_in = b;
    @(posedge clk);
    sb.push_back({ed, ev, ea});
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] nd,
                           input logic nv, input logic na);
    for (int i = 7; i >= 1; i--) drive_bit(b[i], cur_d, cur_v, cur_a);
    cur_d = nd;
    cur_v = nv;
    cur_a = na;
    drive_bit(b[0], cur_d, cur_v, cur_a);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = i[0];
      @(posedge clk);
      sb.push_back(10'd0);
      #1;
    end
    reset = 1'b0;
    cur_d = 8'h00;
    cur_v = 1'b0;
    cur_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    data_in = 1'b0;
    cur_d   = 8'h00;
    cur_v   = 1'b0;
    cur_a   = 1'b0;

    phase = "t1_reset";
    do_reset(3);

    phase = "t2_lock";
    drive_bit(1'b1, 8'h00, 1'b0, 1'b0);
    drive_bit(1'b0, 8'h00, 1'b0, 1'b0);
    drive_bit(1'b1, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);
    send_byte(8'h55, 8'h55, 1'b1, 1'b1);
    send_byte(8'hA3, 8'hA3, 1'b1, 1'b1);

    phase = "t3_broken_run";
    do_reset(2);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);

    phase = "t4_com_in_active";
    send_byte(8'hBC, 8'hBC, 1'b0, 1'b1);
    send_byte(8'h7C, 8'h7C, 1'b1, 1'b1);
    send_byte(8'hBC, 8'hBC, 1'b0, 1'b1);

    phase = "t5_straddle";
    send_byte(8'h0B, 8'h0B, 1'b1, 1'b1);
    send_byte(8'hC0, 8'hC0, 1'b1, 1'b1);

    phase = "t6_relock";
    drive_bit(1'b1, cur_d, cur_v, cur_a);
    drive_bit(1'b0, cur_d, cur_v, cur_a);
    drive_bit(1'b1, cur_d, cur_v, cur_a);
    do_reset(1);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1);
    send_byte(8'h11, 8'h11, 1'b1, 1'b1);
    send_byte(8'h00, 8'h00, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
